// File: rtl/difftest_csr_pkg.sv
// Shared widths, CSR field indices and the pipeline snapshot record
// for the difftest CSR-state feeder.
package difftest_csr_pkg;

    localparam int CSR_NUM = 18;
    localparam int CSR_W   = 64;
    localparam int SNAP_W  = CSR_NUM * CSR_W;

    // Field order inside a packed snapshot; index 0 sits in bits [63:0]
    localparam int CSR_IDX_PRIVILEGE_MODE = 0;
    localparam int CSR_IDX_MSTATUS        = 1;
    localparam int CSR_IDX_SSTATUS        = 2;
    localparam int CSR_IDX_MEPC           = 3;
    localparam int CSR_IDX_SEPC           = 4;
    localparam int CSR_IDX_MTVAL          = 5;
    localparam int CSR_IDX_STVAL          = 6;
    localparam int CSR_IDX_MTVEC          = 7;
    localparam int CSR_IDX_STVEC          = 8;
    localparam int CSR_IDX_MCAUSE         = 9;
    localparam int CSR_IDX_SCAUSE         = 10;
    localparam int CSR_IDX_SATP           = 11;
    localparam int CSR_IDX_MIP            = 12;
    localparam int CSR_IDX_MIE            = 13;
    localparam int CSR_IDX_MSCRATCH       = 14;
    localparam int CSR_IDX_SSCRATCH       = 15;
    localparam int CSR_IDX_MIDELEG        = 16;
    localparam int CSR_IDX_MEDELEG        = 17;

    typedef struct packed {
        logic              valid;
        logic              trap;
        logic [SNAP_W-1:0] data;
    } snap_t;

    function automatic logic [CSR_W-1:0] csr_field(input logic [SNAP_W-1:0] snap, input int idx);
        return snap[idx*CSR_W +: CSR_W];
    endfunction

endpackage

// File: rtl/difftest_csr_snapshot_if.sv
// Commit-side inputs and sink-side outputs of the CSR snapshot feeder.
// master drives commits and observes the sink side; slave is the feeder.
interface difftest_csr_snapshot_if;
    import difftest_csr_pkg::*;

    logic              commit_valid;
    logic              commit_trap;
    logic              flush;
    logic [SNAP_W-1:0] csr_in;
    logic              out_enable;
    logic [SNAP_W-1:0] out_csr;
    logic [7:0]        out_coreid;
    logic [31:0]       suppressed_cnt;

    modport master (
        output commit_valid, commit_trap, flush, csr_in,
        input  out_enable, out_csr, out_coreid, suppressed_cnt
    );

    modport slave (
        input  commit_valid, commit_trap, flush, csr_in,
        output out_enable, out_csr, out_coreid, suppressed_cnt
    );

endinterface

// File: rtl/difftest_csr_delay_pipe.sv
// DELAY-deep shift register of snapshots. Stage 0 loads the capture every
// cycle; flush kills every older entry but still accepts the new capture.
module difftest_csr_delay_pipe
    import difftest_csr_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  flush,
    input  snap_t capture_snap,
    output snap_t tail_snap
);

    generate
        for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
            snap_t stage_reg;

            if (gi == 0) begin : g_head
                always_ff @(posedge clock) begin
                    if (reset) begin
                        stage_reg.valid <= 1'b0;
                    end else begin
                        stage_reg.valid <= capture_snap.valid;
                    end
                    // payload only moves on a real commit; it is don't-care otherwise
                    if (capture_snap.valid) begin
                        stage_reg.trap <= capture_snap.trap;
                        stage_reg.data <= capture_snap.data;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clock) begin
                    if (reset || flush) begin
                        stage_reg.valid <= 1'b0;
                    end else begin
                        stage_reg.valid <= g_stage[gi-1].stage_reg.valid;
                    end
                    stage_reg.trap <= g_stage[gi-1].stage_reg.trap;
                    stage_reg.data <= g_stage[gi-1].stage_reg.data;
                end
            end
        end
    endgenerate

    assign tail_snap = g_stage[DELAY-1].stage_reg;

endmodule

// File: rtl/difftest_csr_snapshot.sv
// Captures CSR state at commit, delays it DELAY cycles and strobes it to the
// difftest sink. Define DIFFTEST_CSR_DEDUP_EN to suppress repeated snapshots.
module difftest_csr_snapshot
    import difftest_csr_pkg::*;
#(
    parameter int         DELAY     = 2,
    parameter int         HEARTBEAT = 64,
    parameter logic [7:0] CORE_ID   = 8'd0
) (
    input logic                     clock,
    input logic                     reset,
    difftest_csr_snapshot_if.slave  bus
);

    snap_t             capture_snap;
    snap_t             tail_snap;
    logic              tail_live;
    logic              emit;
    logic              out_enable_reg;
    logic [SNAP_W-1:0] out_csr_reg;

    always_comb begin
        capture_snap       = '0;
        capture_snap.valid = bus.commit_valid;
        capture_snap.trap  = bus.commit_valid & bus.commit_trap;
        capture_snap.data  = bus.csr_in;
    end

    difftest_csr_delay_pipe #(
        .DELAY (DELAY)
    ) u_delay_pipe (
        .clock        (clock),
        .reset        (reset),
        .flush        (bus.flush),
        .capture_snap (capture_snap),
        .tail_snap    (tail_snap)
    );

    // A flush in the decision cycle kills the tail entry too
    assign tail_live = tail_snap.valid & ~bus.flush;

`ifdef DIFFTEST_CSR_DEDUP_EN
    localparam logic [31:0] HB_LIMIT = 32'(HEARTBEAT);

    logic [SNAP_W-1:0] last_emitted_reg;
    logic              first_pending_reg;
    logic [31:0]       hb_cnt_reg;
    logic [31:0]       suppressed_cnt_reg;
    logic              hb_due;
    logic              suppress;

    assign hb_due   = (HEARTBEAT != 0) && (hb_cnt_reg == HB_LIMIT);
    assign emit     = tail_live & (first_pending_reg | tail_snap.trap |
                                   (tail_snap.data != last_emitted_reg) | hb_due);
    assign suppress = tail_live & ~emit;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_emitted_reg   <= '0;
            first_pending_reg  <= 1'b1;
            hb_cnt_reg         <= '0;
            suppressed_cnt_reg <= '0;
        end else if (emit) begin
            last_emitted_reg  <= tail_snap.data;
            first_pending_reg <= 1'b0;
            hb_cnt_reg        <= '0;
        end else if (suppress) begin
            // with HEARTBEAT=0 the limit is 0, so hb_cnt simply stays parked
            if (hb_cnt_reg != HB_LIMIT) begin
                hb_cnt_reg <= hb_cnt_reg + 32'd1;
            end
            if (suppressed_cnt_reg != 32'hFFFF_FFFF) begin
                suppressed_cnt_reg <= suppressed_cnt_reg + 32'd1;
            end
        end
    end

    assign bus.suppressed_cnt = suppressed_cnt_reg;
`else
    localparam int unused_heartbeat = HEARTBEAT;
    logic unused_trap;

    assign unused_trap        = tail_snap.trap;
    assign emit               = tail_live;
    assign bus.suppressed_cnt = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out_enable_reg <= 1'b0;
            out_csr_reg    <= '0;
        end else begin
            out_enable_reg <= emit;
            if (emit) begin
                out_csr_reg <= tail_snap.data;
            end
        end
    end

    assign bus.out_enable = out_enable_reg;
    assign bus.out_csr    = out_csr_reg;
    assign bus.out_coreid = CORE_ID;

endmodule

// File: tb/tb_difftest_csr_snapshot.sv
// Directed plan scenarios plus randomized commits/flushes/resets, all checked
// against a queue-based reference model of the snapshot feeder.
module tb_difftest_csr_snapshot;
    import difftest_csr_pkg::*;

    localparam int         DELAY   = 2;
    localparam int         HB      = 4;
    localparam logic [7:0] CORE    = 8'h5A;
`ifdef DIFFTEST_CSR_DEDUP_EN
    localparam bit         DEDUP   = 1'b1;
`else
    localparam bit         DEDUP   = 1'b0;
`endif

    logic clock;
    logic reset;
    difftest_csr_snapshot_if bus ();

    difftest_csr_snapshot #(
        .DELAY     (DELAY),
        .HEARTBEAT (HB),
        .CORE_ID   (CORE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int obs_pulses = 0;

    // Reference model: pending commits with their commit cycle; each is judged
    // DELAY cycles after it was committed.
    typedef struct {
        int                c;
        bit                trap;
        logic [SNAP_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    logic              exp_en;
    logic [SNAP_W-1:0] exp_csr;
    logic [31:0]       exp_supp;
`ifdef DIFFTEST_CSR_DEDUP_EN
    bit                m_first;
    logic [SNAP_W-1:0] m_last;
    int                m_hb;
`endif

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input bit cv, input bit tr, input bit fl, input bit rs,
                              input logic [SNAP_W-1:0] d);
        ent_t e;
        bit   do_emit;
        if (rs) begin
            q.delete();
            exp_en   = 1'b0;
            exp_csr  = '0;
            exp_supp = '0;
`ifdef DIFFTEST_CSR_DEDUP_EN
            m_first = 1'b1;
            m_last  = '0;
            m_hb    = 0;
`endif
        end else begin
            exp_en = 1'b0;
            if (fl) begin
                q.delete();
            end else if (q.size() > 0 && q[0].c + DELAY == cyc) begin
                e = q.pop_front();
`ifdef DIFFTEST_CSR_DEDUP_EN
                do_emit = m_first || e.trap || (e.d != m_last) || (HB != 0 && m_hb == HB);
                if (!do_emit) begin
                    if (m_hb < HB) m_hb++;
                    if (exp_supp != 32'hFFFF_FFFF) exp_supp++;
                end else begin
                    m_last  = e.d;
                    m_first = 1'b0;
                    m_hb    = 0;
                end
`else
                do_emit = 1'b1;
`endif
                if (do_emit) begin
                    exp_en  = 1'b1;
                    exp_csr = e.d;
                end
            end
            if (cv) q.push_back('{c: cyc, trap: tr, d: d});
        end
        cyc++;
    endtask

    task automatic tick(input bit cv, input bit tr, input bit fl, input bit rs,
                        input logic [SNAP_W-1:0] d);
        bus.commit_valid = cv;
        bus.commit_trap  = tr;
        bus.flush        = fl;
        bus.csr_in       = d;
        reset            = rs;
        model_step(cv, tr, fl, rs, d);
        @(posedge clock);
        #1;
        check_val("out_enable", {63'd0, bus.out_enable}, {63'd0, exp_en});
        check_val("suppressed_cnt", {32'd0, bus.suppressed_cnt}, {32'd0, exp_supp});
        check_val("out_coreid", {56'd0, bus.out_coreid}, {56'd0, CORE});
        for (int i = 0; i < CSR_NUM; i++) begin
            check_val($sformatf("out_csr[%0d]", i), bus.out_csr[i*CSR_W +: CSR_W],
                      exp_csr[i*CSR_W +: CSR_W]);
        end
        if (bus.out_enable === 1'b1) begin
            obs_pulses++;
            $display("txn cycle %0d: emit mstatus=%h suppressed=%0d", cyc,
                     csr_field(bus.out_csr, CSR_IDX_MSTATUS), bus.suppressed_cnt);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
        obs_pulses = 0;
    endtask

    function automatic logic [SNAP_W-1:0] rand_snap();
        logic [SNAP_W-1:0] r;
        for (int i = 0; i < SNAP_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [SNAP_W-1:0] snap_a, snap_b, d_plan;
    logic [SNAP_W-1:0] pool [3];

    initial begin
        bus.commit_valid = 1'b0;
        bus.commit_trap  = 1'b0;
        bus.flush        = 1'b0;
        bus.csr_in       = '0;
        reset            = 1'b1;
        snap_a = rand_snap();
        snap_b = rand_snap();

        // Reset state, then first commit appears exactly three cycles later
        do_reset();
        d_plan = '0;
        d_plan[CSR_IDX_MSTATUS*CSR_W +: CSR_W] = 64'hA_0000_0000;
        tick(1'b1, 1'b0, 1'b0, 1'b0, d_plan);
        idle(1);
        check_val("plan1_early", {63'd0, bus.out_enable}, 64'd0);
        idle(1);
        check_val("plan1_en", {63'd0, bus.out_enable}, 64'd1);
        check_val("plan1_mstatus", bus.out_csr[127:64], 64'hA_0000_0000);
        idle(3);

        // Back-to-back identical commits
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        idle(5);
        check_val("dup_pulses", obs_pulses, DEDUP ? 64'd1 : 64'd2);
        check_val("dup_supp", {32'd0, bus.suppressed_cnt}, DEDUP ? 64'd1 : 64'd0);

        // Trap forces the repeat out
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        tick(1'b1, 1'b1, 1'b0, 1'b0, snap_a);
        idle(5);
        check_val("trap_pulses", obs_pulses, 64'd2);

        // Heartbeat: six identical commits with HEARTBEAT=4
        do_reset();
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        idle(5);
        check_val("hb_pulses", obs_pulses, DEDUP ? 64'd2 : 64'd6);
        check_val("hb_supp", {32'd0, bus.suppressed_cnt}, DEDUP ? 64'd4 : 64'd0);

        // Flush drops the older commit but keeps the one arriving with it
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        tick(1'b1, 1'b0, 1'b1, 1'b0, snap_b);
        idle(1);
        check_val("flush_early", {63'd0, bus.out_enable}, 64'd0);
        idle(1);
        check_val("flush_en", {63'd0, bus.out_enable}, 64'd1);
        check_val("flush_data", bus.out_csr[127:64], snap_b[127:64]);
        idle(4);
        check_val("flush_pulses", obs_pulses, 64'd1);

        // Reset mid-pipeline drops the commit; next identical commit still emits
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        idle(5);
        obs_pulses = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle(5);
        check_val("rst_drop_pulses", obs_pulses, 64'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, snap_a);
        idle(5);
        check_val("rst_first_pulses", obs_pulses, 64'd1);

        // Randomized traffic with heavy repetition so dedup paths get exercised
        pool[0] = snap_a;
        pool[1] = snap_b;
        pool[2] = rand_snap();
        for (int n = 0; n < 2000; n++) begin
            logic [SNAP_W-1:0] d;
            bit cv, tr, fl, rs;
            d = pool[($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 2)];
            if ($urandom_range(0, 19) == 0) d[$urandom_range(0, SNAP_W-1)] ^= 1'b1;
            cv = ($urandom_range(0, 9) < 7);
            tr = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 99) == 0);
            tick(cv, tr, fl, rs, d);
        end
        idle(DELAY + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
